dphy_lane_deskew: RTL and testbench
===================================

DPHY_LANE_DESKEW -- requirements
Module: dphy_lane_deskew

Interface
REQ-001 SHALL have parameter DATA_LANES, default 4, meaning the number of physical D-PHY data lanes; legal values are 1 to 8.
REQ-002 SHALL have parameter MAX_SKEW, default 3, meaning the maximum tolerated inter-lane arrival skew in byte clocks; legal values are 1 to 15.
REQ-003 SHALL have port byte_clk_i, input, 1 bit: the byte clock, which is the single clock of the block.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 SHALL have port enable_i, input, 1 bit: block enable.
REQ-006 SHALL have port active_lanes_i, input, 4 bits: runtime active lane count, 1 to DATA_LANES; it is sampled only in IDLE.
REQ-007 SHALL have port wait_for_sync_i, input, 1 bit: arms the block for the next packet.
REQ-008 SHALL have port pkt_done_i, input, 1 bit: upstream end-of-packet indication.
REQ-009 SHALL have port byte_data_i, input, DATA_LANES x 8 bits: per-lane byte.
REQ-010 SHALL have port valid_i, input, DATA_LANES bits: per-lane byte valid.
REQ-011 SHALL have port word_o, output, DATA_LANES x 8 bits: aligned word.
REQ-012 SHALL have port keep_o, output, DATA_LANES bits: lanes carrying a valid byte in word_o.
REQ-013 SHALL have port valid_o, output, 1 bit: word_o and keep_o are valid.
REQ-014 SHALL have port pkt_done_o, output, 1 bit: single-cycle pulse emitted after the last word of a packet.
REQ-015 SHALL have port skew_err_o, output, 1 bit: single-cycle pulse emitted when the skew limit is exceeded.

Function
REQ-016 SHALL use FSM states IDLE, SYNC, ALIGNED and DRAIN.
REQ-017 SHALL give each lane a FIFO of depth MAX_SKEW+2, written on every cycle where valid_i[lane] is high in states SYNC, ALIGNED or DRAIN, and only for lanes below the latched active lane count.
REQ-018 SHALL ignore bytes on inactive lanes; keep_o SHALL be 0 for inactive lanes.
REQ-019 IDLE -> SYNC SHALL occur when enable_i = 1 and wait_for_sync_i = 1; on this transition the block SHALL latch active_lanes_i, clamping 0 to 1 and values above DATA_LANES to DATA_LANES.
REQ-020 In SYNC, the skew counter SHALL start at 0 on the first cycle any active lane has valid_i high, and increment every cycle until all active lanes have written at least one byte.
REQ-021 If the skew counter reaches MAX_SKEW+1 in SYNC, the block SHALL pulse skew_err_o for one cycle, flush all FIFOs and return to IDLE; a skew of exactly MAX_SKEW SHALL be accepted.
REQ-022 SYNC -> ALIGNED SHALL occur when all active FIFOs are non-empty.
REQ-023 In ALIGNED, the block SHALL pop all active FIFOs simultaneously whenever all are non-empty, registering word_o, keep_o = active mask, and valid_o = 1 on the next edge.
REQ-024 Latency: when the last lane's first byte is sampled at edge k, the first valid_o SHALL be high after edge k+1.
REQ-025 ALIGNED -> DRAIN SHALL occur when pkt_done_i = 1, or when any active lane's valid_i falls.
REQ-026 In DRAIN, the block SHALL pop every non-empty active FIFO each cycle, with keep_o marking exactly the popped lanes and valid_o = 1 if any lane was popped.
REQ-027 In DRAIN, when all FIFOs are empty and all valid_i are low, the block SHALL pulse pkt_done_o for one cycle, concurrent with the cycle after the last valid_o, and return to IDLE.
REQ-028 Across each packet, bytes SHALL leave each lane in arrival order, and word_o byte lane i SHALL always come from input lane i.
REQ-029 enable_i = 0 in any state SHALL synchronously flush the FIFOs, zero valid_o, keep_o and the pulse outputs, and force IDLE on the next edge.
REQ-030 In IDLE, the block SHALL discard valid_i and write no FIFO.
REQ-031 FIFO overflow SHALL be impossible by construction; a write to a full FIFO SHALL be treated as a skew error, handled exactly as in REQ-021.
REQ-032 If pkt_done_i and skew overflow coincide in SYNC, the skew error SHALL win.
REQ-033 If pkt_done_i is asserted in SYNC before alignment is reached, the block SHALL flush and return to IDLE with no pkt_done_o.
REQ-034 wait_for_sync_i asserted in ALIGNED or DRAIN SHALL have no effect.

Reset
REQ-035 rst_i = 0 SHALL asynchronously force IDLE, empty all FIFOs, zero the skew counter and the latched lane count, and set word_o = 0, keep_o = 0, valid_o = 0, pkt_done_o = 0 and skew_err_o = 0.
REQ-036 Reset deassertion SHALL be synchronised to byte_clk_i.
REQ-037 Reset asserted mid-packet SHALL discard all buffered bytes, with no pkt_done_o.

Verification
REQ-038 Scenario: DATA_LANES=4, MAX_SKEW=3; lanes start at cycles 0/1/1/2 with incrementing bytes 0x00 upward -> valid_o high 2 edges after lane 3's first byte, first word_o = {00,00,00,00}, then incrementing by 1 per lane.
REQ-039 Scenario: lane 3 starts 3 cycles after lane 0 -> accepted and aligned; lane 3 starts 4 cycles after lane 0 -> skew_err_o pulse, no valid_o, state IDLE.
REQ-040 Scenario: active_lanes_i=2 with all 4 lanes driven -> keep_o = 0011, and lanes 2 and 3 are never written.
REQ-041 Scenario: 10-byte packet on 4 lanes, with lanes 0-1 carrying 3 bytes and lanes 2-3 carrying 2 -> last word has keep_o = 0011, and pkt_done_o is pulsed the following cycle.
REQ-042 Scenario: rst_i pulled low mid-ALIGNED -> all outputs 0 immediately, and the next packet aligns correctly after re-arming with wait_for_sync_i.
REQ-043 Scenario: enable_i deasserted for 1 cycle in DRAIN -> no pkt_done_o, state IDLE, FIFOs empty.

Source files
------------

// File: rtl/dphy_lane_deskew.sv
// D-PHY lane deskew: buffers each lane's bytes until every active lane has
// delivered its first byte, then releases them as aligned words so that
// word_o byte lane i always carries the next byte from input lane i.
module dphy_lane_deskew #(
    parameter int DATA_LANES = 4,
    parameter int MAX_SKEW   = 3
) (
    input  logic                    byte_clk_i,
    input  logic                    rst_i,
    input  logic                    enable_i,
    input  logic [3:0]              active_lanes_i,
    input  logic                    wait_for_sync_i,
    input  logic                    pkt_done_i,
    input  logic [DATA_LANES*8-1:0] byte_data_i,
    input  logic [DATA_LANES-1:0]   valid_i,
    output logic [DATA_LANES*8-1:0] word_o,
    output logic [DATA_LANES-1:0]   keep_o,
    output logic                    valid_o,
    output logic                    pkt_done_o,
    output logic                    skew_err_o
);
    localparam int DEPTH = MAX_SKEW + 2;
    localparam int AW    = $clog2(DEPTH);
    localparam int PW    = $clog2(DEPTH + 1);
    localparam int SW    = $clog2(MAX_SKEW + 2);

    typedef enum logic [1:0] {IDLE, SYNC, ALIGNED, DRAIN} state_t;

    state_t                state, state_nx;
    logic [1:0]            rst_sync;
    logic                  rst_n;
    logic [3:0]            lanes_q, lanes_clamped;
    logic                  started;
    logic [SW-1:0]         skew_cnt;
    logic [DATA_LANES-1:0] valid_q;
    logic [7:0]            mem [DATA_LANES][DEPTH];
    logic [AW-1:0]         wr_ptr [DATA_LANES];
    logic [AW-1:0]         rd_ptr [DATA_LANES];
    logic [PW-1:0]         cnt [DATA_LANES];
    logic [DATA_LANES-1:0] active_mask, v_act, wr, pop, empty, full;
    logic                  ready, all_nonempty, fell, skew_over, overflow;
    logic                  flush, skew_err_nx, done_nx;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Reset asserts asynchronously but releases only on a clock edge.
    always_ff @(posedge byte_clk_i or negedge rst_i) begin
        if (!rst_i) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    for (genvar g = 0; g < DATA_LANES; g++) begin : g_lane
        assign active_mask[g] = lanes_q > 4'(g);
        assign empty[g]       = cnt[g] == '0;
        assign full[g]        = cnt[g] == PW'(DEPTH);
    end

    assign v_act        = valid_i & active_mask;
    assign wr           = (state == IDLE) ? '0 : v_act;
    assign ready        = &(~empty | wr | ~active_mask);
    assign all_nonempty = &(~empty | ~active_mask);
    assign fell         = |(valid_q & ~valid_i & active_mask);
    assign skew_over    = started && (skew_cnt == SW'(MAX_SKEW + 1));
    assign overflow     = |(wr & full & ~pop);

    // Clamp the requested lane count into 1..DATA_LANES.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        lanes_clamped = active_lanes_i;
        if (active_lanes_i == 4'd0)                 lanes_clamped = 4'd1;
        else if (active_lanes_i > 4'(DATA_LANES))   lanes_clamped = 4'(DATA_LANES);
    end

    // Pop all lanes together once aligned; drain each lane independently at the end.
    always_comb begin
        pop = '0;
        if (enable_i) begin
            if (state == ALIGNED && all_nonempty) pop = active_mask;
            else if (state == DRAIN)              pop = ~empty & active_mask;
        end
    end

    // Next-state and pulse decisions; a skew error always beats an end of packet.
    always_comb begin
        state_nx    = state;
        flush       = 1'b0;
        skew_err_nx = 1'b0;
        done_nx     = 1'b0;
        if (!enable_i) begin
            state_nx = IDLE;
            flush    = 1'b1;
        end else begin
            case (state)
                IDLE: if (wait_for_sync_i) state_nx = SYNC;
                SYNC: begin
                    if (skew_over || overflow) begin
                        state_nx    = IDLE;
                        flush       = 1'b1;
                        skew_err_nx = 1'b1;
                    end else if (pkt_done_i) begin
                        state_nx = IDLE;
                        flush    = 1'b1;
                    end else if (ready) begin
                        state_nx = ALIGNED;
                    end
                end
                ALIGNED: begin
                    if (overflow) begin
                        state_nx    = IDLE;
                        flush       = 1'b1;
                        skew_err_nx = 1'b1;
                    end else if (pkt_done_i || fell) begin
                        state_nx = DRAIN;
                    end
                end
                DRAIN: begin
                    if (overflow) begin
                        state_nx    = IDLE;
                        flush       = 1'b1;
                        skew_err_nx = 1'b1;
                    end else if (&empty && v_act == '0) begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge byte_clk_i or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Lane-count latch, skew counter and previous-cycle valids for fall detection.
    always_ff @(posedge byte_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            lanes_q  <= '0;
            started  <= 1'b0;
            skew_cnt <= '0;
            valid_q  <= '0;
        end else begin
            valid_q <= valid_i;
            if (state == IDLE && state_nx == SYNC) lanes_q <= lanes_clamped;
            if (state == SYNC && state_nx == SYNC) begin
                if (started) begin
                    skew_cnt <= skew_cnt + SW'(1);
                end else if (|v_act) begin
                    started  <= 1'b1;
                    skew_cnt <= SW'(1);
                end
            end else begin
                started  <= 1'b0;
                skew_cnt <= '0;
            end
        end
    end

    // Per-lane FIFO pointers and occupancy.
    always_ff @(posedge byte_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DATA_LANES; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                cnt[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < DATA_LANES; i++) begin
                if (flush) begin
                    wr_ptr[i] <= '0;
                    rd_ptr[i] <= '0;
                    cnt[i]    <= '0;
                end else begin
                    if (wr[i])  wr_ptr[i] <= next_ptr(wr_ptr[i]);
                    if (pop[i]) rd_ptr[i] <= next_ptr(rd_ptr[i]);
                    cnt[i] <= cnt[i] + PW'(wr[i]) - PW'(pop[i]);
                end
            end
        end
    end

    // FIFO storage.
    // NOTE: storage has no reset; the occupancy counters alone decide which entries are live.
    always_ff @(posedge byte_clk_i) begin
        for (int i = 0; i < DATA_LANES; i++)
            if (wr[i] && !flush) mem[i][wr_ptr[i]] <= byte_data_i[i*8 +: 8];
    end

    // Registered outputs: popped bytes, keep mask and the two single-cycle pulses.
    always_ff @(posedge byte_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            word_o     <= '0;
            keep_o     <= '0;
            valid_o    <= 1'b0;
            pkt_done_o <= 1'b0;
            skew_err_o <= 1'b0;
        end else begin
            valid_o    <= !flush && (|pop);
            keep_o     <= flush ? '0 : pop;
            pkt_done_o <= done_nx;
            skew_err_o <= skew_err_nx;
            for (int i = 0; i < DATA_LANES; i++)
                word_o[i*8 +: 8] <= (pop[i] && !flush) ? mem[i][rd_ptr[i]] : 8'h00;
        end
    end
endmodule

// File: tb/tb_dphy_lane_deskew.sv
// Bench for dphy_lane_deskew: packets are described per lane (start cycle,
// length, bytes) and the expected output stream is derived from that
// description: word j holds byte j of every active lane long enough to have
// one, the first word appears one edge after the last lane's first byte, and
// pkt_done follows the last word by one edge.
module tb_dphy_lane_deskew;
    localparam int L  = 4;
    localparam int MS = 3;
    localparam int NT = 64;

    logic           clk = 1'b0;
    logic           rst_i, enable_i, wait_for_sync_i, pkt_done_i;
    logic [3:0]     active_lanes_i;
    logic [L*8-1:0] byte_data_i;
    logic [L-1:0]   valid_i;
    logic [L*8-1:0] word_o;
    logic [L-1:0]   keep_o;
    logic           valid_o, pkt_done_o, skew_err_o;

    always #5 clk = ~clk;

    dphy_lane_deskew #(.DATA_LANES(L), .MAX_SKEW(MS)) dut (
        .byte_clk_i     (clk),
        .rst_i          (rst_i),
        .enable_i       (enable_i),
        .active_lanes_i (active_lanes_i),
        .wait_for_sync_i(wait_for_sync_i),
        .pkt_done_i     (pkt_done_i),
        .byte_data_i    (byte_data_i),
        .valid_i        (valid_i),
        .word_o         (word_o),
        .keep_o         (keep_o),
        .valid_o        (valid_o),
        .pkt_done_o     (pkt_done_o),
        .skew_err_o     (skew_err_o)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int          off [L];
    int          len [L];
    logic [7:0]  dat [L][16];
    logic [38:0] exp_vec [NT];   // {done, err, valid, keep[3:0], word[31:0]}

    task automatic check(input string tag, input logic [38:0] obs, input logic [38:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %h required %h", tag, obs, expv);
    endtask

    // Output snapshot; word bytes outside the mask are don't-care and zeroed.
    function automatic logic [38:0] observed(input logic [3:0] mask);
        logic [31:0] w;
        for (int i = 0; i < L; i++) w[i*8 +: 8] = mask[i] ? word_o[i*8 +: 8] : 8'h00;
        return {pkt_done_o, skew_err_o, valid_o, keep_o, w};
    endfunction

    task automatic set_pkt(input int o0, o1, o2, o3, l0, l1, l2, l3, input bit incr);
        off[0] = o0; off[1] = o1; off[2] = o2; off[3] = o3;
        len[0] = l0; len[1] = l1; len[2] = l2; len[3] = l3;
        for (int i = 0; i < L; i++)
            for (int j = 0; j < 16; j++) dat[i][j] = incr ? 8'(j) : 8'($urandom);
    endtask

    // Expected output per edge after arming; everything from 'kill' on is silent.
    task automatic build_model(input int n_act, input int kill, output int t_end);
        int a, maxlen;
        logic [3:0]  k;
        logic [31:0] w;
        a = 0; maxlen = 0; t_end = 0;
        for (int t = 0; t < NT; t++) exp_vec[t] = '0;
        for (int i = 0; i < L; i++) if (off[i] + len[i] > t_end) t_end = off[i] + len[i];
        for (int i = 0; i < n_act; i++) begin
            if (off[i] > a)      a = off[i];
            if (len[i] > maxlen) maxlen = len[i];
        end
        if (a > MS) begin
            exp_vec[MS + 1][37] = 1'b1;
        end else begin
            for (int j = 0; j < maxlen; j++) begin
                k = '0; w = '0;
                for (int i = 0; i < n_act; i++)
                    if (len[i] > j) begin k[i] = 1'b1; w[i*8 +: 8] = dat[i][j]; end
                exp_vec[a + 1 + j] = {1'b0, 1'b0, 1'b1, k, w};
            end
            exp_vec[a + 1 + maxlen][38] = 1'b1;
            if (a + 1 + maxlen > t_end) t_end = a + 1 + maxlen;
        end
        if (kill >= 0) for (int t = kill; t < NT; t++) exp_vec[t] = '0;
        t_end = t_end + 2;
    endtask

    // mode 0: clean packet, 1: enable low for cycle 'kill', 2: reset from cycle 'kill'.
    task automatic run_packet(input string tag, input logic [3:0] lanes_in, input int mode, input int kill);
        int n_act, t_end;
        n_act = (lanes_in == 4'd0) ? 1 : (lanes_in > 4'(L)) ? L : int'(lanes_in);
        build_model(n_act, kill, t_end);
        active_lanes_i  = lanes_in;
        wait_for_sync_i = 1'b1;
        @(posedge clk); #1;
        wait_for_sync_i = 1'b0;
        check({tag, " arm"}, observed(4'h0), '0);
        for (int t = 0; t <= t_end; t++) begin
            for (int i = 0; i < L; i++) begin
                valid_i[i] = (t >= off[i]) && (t < off[i] + len[i]);
                byte_data_i[i*8 +: 8] = valid_i[i] ? dat[i][t - off[i]] : 8'($urandom);
            end
            enable_i = !(mode == 1 && t == kill);
            if (mode == 2 && t == kill) begin
                #2 rst_i = 1'b0;
                #1 check({tag, " rst_async"}, observed(4'hF), '0);
            end
            @(posedge clk); #1;
            check($sformatf("%s t=%0d", tag, t), observed(exp_vec[t][35:32]), exp_vec[t]);
        end
        valid_i = '0; byte_data_i = '0; enable_i = 1'b1; rst_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 check({tag, " idle_after"}, observed(4'h0), '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] lanes;
        rst_i = 1'b0; enable_i = 1'b0; wait_for_sync_i = 1'b0; pkt_done_i = 1'b0;
        active_lanes_i = 4'd4; byte_data_i = '0; valid_i = '0;
        repeat (3) @(posedge clk);
        #1 check("reset", observed(4'hF), '0);
        rst_i = 1'b1; enable_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("post_reset", observed(4'hF), '0);

        // Bytes offered in IDLE are discarded: nothing out now, nothing stale later.
        for (int t = 0; t < 4; t++) begin
            valid_i = '1; byte_data_i = 32'($urandom);
            @(posedge clk); #1;
            check($sformatf("idle_discard t=%0d", t), observed(4'h0), '0);
        end
        valid_i = '0;
        @(posedge clk); #1;

        set_pkt(0, 1, 1, 2, 6, 6, 6, 6, 1'b1);
        run_packet("stagger_0112", 4'd4, 0, -1);

        set_pkt(0, 0, 0, 3, 7, 7, 7, 7, 1'b0);
        run_packet("skew_max", 4'd4, 0, -1);

        set_pkt(0, 0, 0, 4, 7, 7, 7, 7, 1'b0);
        run_packet("skew_over", 4'd4, 0, -1);

        set_pkt(0, 1, 0, 0, 5, 5, 5, 5, 1'b0);
        run_packet("two_lanes", 4'd2, 0, -1);

        set_pkt(0, 0, 0, 0, 3, 3, 2, 2, 1'b0);
        run_packet("ten_bytes", 4'd4, 0, -1);

        set_pkt(0, 0, 0, 0, 8, 8, 8, 8, 1'b0);
        run_packet("rst_aligned", 4'd4, 2, 3);
        set_pkt(0, 2, 1, 0, 6, 6, 6, 6, 1'b0);
        run_packet("after_rst", 4'd4, 0, -1);

        set_pkt(0, 0, 0, 0, 6, 6, 6, 2, 1'b0);
        run_packet("en_drop_drain", 4'd4, 1, 3);
        set_pkt(0, 1, 2, 3, 6, 6, 6, 6, 1'b0);
        run_packet("after_en_drop", 4'd4, 0, -1);

        set_pkt(0, 2, 3, 1, 6, 6, 6, 6, 1'b0);
        run_packet("clamp_zero", 4'd0, 0, -1);
        set_pkt(0, 1, 3, 2, 6, 6, 6, 6, 1'b0);
        run_packet("clamp_high", 4'd12, 0, -1);

        for (int p = 0; p < 20; p++) begin
            lanes = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd4;
            set_pkt(0, $urandom_range(0, MS + 1), $urandom_range(0, MS + 1), $urandom_range(0, MS + 1),
                    $urandom_range(MS + 2, MS + 7), $urandom_range(MS + 2, MS + 7),
                    $urandom_range(MS + 2, MS + 7), $urandom_range(MS + 2, MS + 7), 1'b0);
            run_packet($sformatf("rand%0d", p), lanes, 0, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
